// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI burst receive path.
//               - clog2 : ceiling log2 for sizing counters and indices
//               - ACC_WIDTH / ACC_AXES : accelerometer default word size and
//                 axis count (X/Y/Z)
//               - `SPI_BURST_SLICE(k, w) : part-select of word k inside a
//                 packed burst of w-bit words (word 0 in the LSBs)
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef SPI_BURST_SLICE
`define SPI_BURST_SLICE(k, w) (k)*(w) +: (w)
`endif

package spi_pkg;

  localparam int ACC_WIDTH = 8;
  localparam int ACC_AXES  = 3;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_word.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_word
// Description : Serial-in shift register plus bit counter for one SPI word.
//               Presents the post-shift value and a completion flag
//               combinationally so the caller can register the finished word
//               on the same edge that shifts in its last bit.
// Ports       : ck        - system clock (rising edge)
//               rst       - synchronous active-high reset
//               clr       - frame-off; clears the bit counter, blocks shifting
//               shift_en  - shift miso in on this edge
//               miso      - serial data in
//               word      - register contents after this edge's shift
//               done      - this edge shifts the final bit of the word
//               busy      - a partial word is held (bit counter non-zero)
// Revision    : 1.0 - initial release
// ============================================================================

module spi_shift_word
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             miso,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic             busy
);

  localparam int               CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CNT_W-1:0] bit_cnt;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_next = {sr[WIDTH-2:0], miso};
    end else begin : g_lsb_first
      assign sr_next = {miso, sr[WIDTH-1:1]};
    end
  endgenerate

  assign word = sr_next;
  assign done = shift_en && (bit_cnt == LAST_BIT);
  assign busy = (bit_cnt != '0);

  // sr is not cleared on frame-off: a fresh word overwrites every bit
  // before it can complete, so stale contents never leak out.
  always_ff @(posedge ck) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      sr      <= sr_next;
      bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_burst_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_burst_rx
// Description : Chip-select framed SPI receiver. Deserialises miso into
//               WIDTH-bit words and groups WORDS consecutive words into a
//               burst that is published atomically on burst_out.
// Ports       : ck         - system clock (rising edge)
//               rst        - synchronous active-high reset
//               cs_n       - chip select, active low; high frames off
//               sh_data    - miso holds a valid bit this cycle
//               miso       - serial data in
//               data_out   - last completed word (held)
//               word_valid - one-cycle pulse when data_out updates
//               word_idx   - burst position of the word in data_out
//               burst_out  - last completed burst, word k at [k*WIDTH +: WIDTH]
//               burst_done - one-cycle pulse when burst_out updates
//               abort      - one-cycle pulse when cs_n rises mid word/burst
// Revision    : 1.0 - initial release
// ============================================================================

module spi_burst_rx
  import spi_pkg::*;
#(
  parameter int WIDTH     = ACC_WIDTH,
  parameter int WORDS     = ACC_AXES,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   cs_n,
  input  logic                   sh_data,
  input  logic                   miso,
  output logic [WIDTH-1:0]       data_out,
  output logic                   word_valid,
  output logic [clog2((WORDS < 2) ? 2 : WORDS)-1:0] word_idx,
  output logic [WORDS*WIDTH-1:0] burst_out,
  output logic                   burst_done,
  output logic                   abort
);

  localparam int               IDX_W     = clog2((WORDS < 2) ? 2 : WORDS);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);

  logic                   shift_en;
  logic [WIDTH-1:0]       word;
  logic                   word_done;
  logic                   bit_busy;
  logic [IDX_W-1:0]       word_cnt;
  logic [WORDS*WIDTH-1:0] stage;
  logic [WORDS*WIDTH-1:0] stage_next;

  // cs_n high always wins over sh_data: no shift while framed off.
  assign shift_en = !cs_n && sh_data;

  spi_shift_word #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .ck       (ck),
    .rst      (rst),
    .clr      (cs_n),
    .shift_en (shift_en),
    .miso     (miso),
    .word     (word),
    .done     (word_done),
    .busy     (bit_busy)
  );

  // Staging buffer with the completing word merged into its slot, so the
  // final word of a burst reaches burst_out on the same edge it completes.
  always_comb begin
    stage_next = stage;
    for (int k = 0; k < WORDS; k++) begin
      if (word_cnt == IDX_W'(k)) begin
        stage_next[`SPI_BURST_SLICE(k, WIDTH)] = word;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      data_out   <= '0;
      word_valid <= 1'b0;
      word_idx   <= '0;
      burst_out  <= '0;
      burst_done <= 1'b0;
      abort      <= 1'b0;
      word_cnt   <= '0;
      stage      <= '0;
    end else begin
      word_valid <= 1'b0;
      burst_done <= 1'b0;
      abort      <= 1'b0;
      if (cs_n) begin
        // Staging is left stale; every slot is rewritten before the next
        // burst can complete.
        word_cnt <= '0;
        abort    <= bit_busy || (word_cnt != '0);
      end else if (word_done) begin
        data_out   <= word;
        word_valid <= 1'b1;
        word_idx   <= word_cnt;
        stage      <= stage_next;
        if (word_cnt == LAST_WORD) begin
          burst_out  <= stage_next;
          burst_done <= 1'b1;
          word_cnt   <= '0;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_burst_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_burst_rx
// Description : Self-checking bench. Three receivers share one SPI stimulus:
//               u0 (8-bit, 1 word, MSB first), u1 (8-bit, 1 word, LSB first)
//               and u2 (8-bit, 3 words, MSB first). A monitor logs every
//               output pulse; a word/burst-level model predicts the same log.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_spi_burst_rx;

  typedef struct packed {
    logic [1:0]  inst;
    logic [1:0]  kind;   // 0 word, 1 burst, 2 abort
    logic [3:0]  idx;
    logic [31:0] val;
  } ev_t;

  logic ck = 1'b0;
  logic rst, cs_n, sh_data, miso;

  logic [7:0]  d0, d1, d2;
  logic        wv0, wv1, wv2, bd0, bd1, bd2, ab0, ab1, ab2;
  logic [0:0]  idx0, idx1;
  logic [1:0]  idx2;
  logic [7:0]  b0, b1;
  logic [23:0] b2;

  always #5 ck = ~ck;

  spi_burst_rx #(.WIDTH(8), .WORDS(1), .MSB_FIRST(1'b1)) u0 (
    .ck(ck), .rst(rst), .cs_n(cs_n), .sh_data(sh_data), .miso(miso),
    .data_out(d0), .word_valid(wv0), .word_idx(idx0), .burst_out(b0),
    .burst_done(bd0), .abort(ab0));
  spi_burst_rx #(.WIDTH(8), .WORDS(1), .MSB_FIRST(1'b0)) u1 (
    .ck(ck), .rst(rst), .cs_n(cs_n), .sh_data(sh_data), .miso(miso),
    .data_out(d1), .word_valid(wv1), .word_idx(idx1), .burst_out(b1),
    .burst_done(bd1), .abort(ab1));
  spi_burst_rx #(.WIDTH(8), .WORDS(3), .MSB_FIRST(1'b1)) u2 (
    .ck(ck), .rst(rst), .cs_n(cs_n), .sh_data(sh_data), .miso(miso),
    .data_out(d2), .word_valid(wv2), .word_idx(idx2), .burst_out(b2),
    .burst_done(bd2), .abort(ab2));

  ev_t act_q[$];
  ev_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  glitch = 0;

  // Reference model state, per receiver
  int          nw[3];
  int          cnt[3];
  logic [31:0] acc[3];
  logic [31:0] last_d[3];
  logic [31:0] last_b[3];
  int          part;

  function automatic ev_t mk(input int i, input int k, input int x, input logic [31:0] v);
    ev_t e;
    e.inst = i[1:0];
    e.kind = k[1:0];
    e.idx  = x[3:0];
    e.val  = v;
    return e;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic        rst_seen = 1'b1;
  logic [7:0]  b0_prev, b1_prev;
  logic [23:0] b2_prev;

  always @(posedge ck) rst_seen <= rst;

  always @(negedge ck) begin
    if (wv0) act_q.push_back(mk(0, 0, int'(idx0), {24'b0, d0}));
    if (bd0) act_q.push_back(mk(0, 1, 0, {24'b0, b0}));
    if (ab0) act_q.push_back(mk(0, 2, 0, 32'b0));
    if (wv1) act_q.push_back(mk(1, 0, int'(idx1), {24'b0, d1}));
    if (bd1) act_q.push_back(mk(1, 1, 0, {24'b0, b1}));
    if (ab1) act_q.push_back(mk(1, 2, 0, 32'b0));
    if (wv2) act_q.push_back(mk(2, 0, int'(idx2), {24'b0, d2}));
    if (bd2) act_q.push_back(mk(2, 1, 0, {8'b0, b2}));
    if (ab2) act_q.push_back(mk(2, 2, 0, 32'b0));
    // burst_out may only move with burst_done (or reset)
    if (rst_seen === 1'b0) begin
      if (b0 !== b0_prev && !bd0) glitch++;
      if (b1 !== b1_prev && !bd1) glitch++;
      if (b2 !== b2_prev && !bd2) glitch++;
    end
    if ((wv0 && ab0) || (wv1 && ab1) || (wv2 && ab2)) glitch++;
    b0_prev = b0;
    b1_prev = b1;
    b2_prev = b2;
  end

  // ---------------- reference model ----------------
  task automatic model_word(input logic [7:0] w);
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      v = (i == 1) ? {24'b0, rev8(w)} : {24'b0, w};
      exp_q.push_back(mk(i, 0, cnt[i], v));
      last_d[i] = v;
      acc[i] = acc[i] | (v << (8 * cnt[i]));
      if (cnt[i] == nw[i] - 1) begin
        exp_q.push_back(mk(i, 1, 0, acc[i]));
        last_b[i] = acc[i];
        acc[i] = 32'b0;
        cnt[i] = 0;
      end else begin
        cnt[i]++;
      end
    end
    part = 0;
  endtask

  task automatic model_cs();
    for (int i = 0; i < 3; i++) begin
      if (part != 0 || cnt[i] != 0) exp_q.push_back(mk(i, 2, 0, 32'b0));
      cnt[i] = 0;
      acc[i] = 32'b0;
    end
    part = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; acc[i] = 0; last_d[i] = 0; last_b[i] = 0;
    end
    part = 0;
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input logic c, input logic s, input logic m);
    cs_n = c; sh_data = s; miso = m;
    @(negedge ck);
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits, input int stall_at, input bit rnd);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) repeat (4) cyc(1'b0, 1'b0, 1'($urandom));
      if (rnd && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b0, 1'($urandom));
      cyc(1'b0, 1'b1, w[7-i]);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int stall_at, input bit rnd);
    send_bits(w, 8, stall_at, rnd);
    model_word(w);
  endtask

  task automatic frame_end();
    cyc(1'b1, 1'($urandom), 1'($urandom));
    model_cs();
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    act_q.delete(); exp_q.delete();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'(i));
    n_total++;
    if ({d0, d1, d2, b0, b1, b2} !== 72'b0)
      $display("FAIL reset_data: got %h required 0", {d0, d1, d2, b0, b1, b2});
    else n_pass++;
    n_total++;
    if ({wv0, wv1, wv2, bd0, bd1, bd2, ab0, ab1, ab2, idx0, idx1, idx2} !== 13'b0)
      $display("FAIL reset_pulses: got %b required 0", {wv0, wv1, wv2, bd0, bd1, bd2, ab0, ab1, ab2});
    else n_pass++;
    n_total++;
    if (act_q.size() != 0) $display("FAIL reset_events: got %0d required 0", act_q.size());
    else n_pass++;
    rst = 1'b0;
    model_reset();
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    act_q.delete(); exp_q.delete();
    w = 8'hA5;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, w[7-i]);
    model_word(w);
    n_total++;
    if ({wv0, bd0, d0, idx0, b0} !== {1'b1, 1'b1, 8'hA5, 1'b0, 8'hA5})
      $display("FAIL single_msb: got wv=%b bd=%b d=%h idx=%0d b=%h required 1 1 a5 0 a5", wv0, bd0, d0, idx0, b0);
    else n_pass++;
    n_total++;
    if ({wv1, d1} !== {1'b1, 8'hA5}) $display("FAIL single_lsb: got wv=%b d=%h required 1 a5", wv1, d1);
    else n_pass++;
    cyc(1'b0, 1'b0, 1'b0);
    n_total++;
    if ({wv0, bd0, wv1, bd1} !== 4'b0) $display("FAIL single_pulse_width: got %b required 0000", {wv0, bd0, wv1, bd1});
    else n_pass++;
    frame_end();
    n_total++;
    if (act_q.size() != exp_q.size()) $display("FAIL single_events count: got %0d required %0d", act_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (act_q[k] !== exp_q[k]) $display("FAIL single_event[%0d]: got %h required %h", k, act_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_burst();
    act_q.delete(); exp_q.delete();
    send_word(8'h12, -1, 1'b0);
    send_word(8'h34, 3, 1'b0);
    send_word(8'h56, -1, 1'b0);
    frame_end();
    n_total++;
    if (b2 !== 24'h563412) $display("FAIL burst_value: got %h required 563412", b2);
    else n_pass++;
    n_total++;
    if (glitch != 0) $display("FAIL burst_atomic: got %0d glitches required 0", glitch);
    else n_pass++;
    n_total++;
    if (act_q.size() != exp_q.size()) $display("FAIL burst_events count: got %0d required %0d", act_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (act_q[k] !== exp_q[k]) $display("FAIL burst_event[%0d]: got %h required %h", k, act_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    act_q.delete(); exp_q.delete();
    send_word(8'hFF, -1, 1'b0);
    send_bits(8'h5A, 5, -1, 1'b0);
    part = 5;
    frame_end();
    n_total++;
    if ({b2, d2} !== {24'h563412, 8'hFF}) $display("FAIL abort_hold: got b=%h d=%h required 563412 ff", b2, d2);
    else n_pass++;
    send_word(8'h01, -1, 1'b0);
    send_word(8'h02, -1, 1'b0);
    send_word(8'h03, -1, 1'b0);
    frame_end();
    n_total++;
    if (b2 !== 24'h030201) $display("FAIL abort_restart: got %h required 030201", b2);
    else n_pass++;
    n_total++;
    if (act_q.size() != exp_q.size()) $display("FAIL abort_events count: got %0d required %0d", act_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (act_q[k] !== exp_q[k]) $display("FAIL abort_event[%0d]: got %h required %h", k, act_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    logic [7:0] w;
    act_q.delete(); exp_q.delete();
    w = 8'hC3;
    send_word(8'h3C, -1, 1'b0);
    send_bits(w, 7, -1, 1'b0);
    cyc(1'b1, 1'b1, w[0]);   // cs_n rises on the edge of bit 8
    part = 7;
    model_cs();
    n_total++;
    if ({ab0, ab1, ab2, wv0, wv1, wv2} !== 6'b111000)
      $display("FAIL collision_pulses: got ab=%b wv=%b required 111 000", {ab0, ab1, ab2}, {wv0, wv1, wv2});
    else n_pass++;
    cyc(1'b1, 1'b0, 1'b0);
    n_total++;
    if ({d0, d2} !== {8'h3C, 8'h3C}) $display("FAIL collision_hold: got %h %h required 3c 3c", d0, d2);
    else n_pass++;
    n_total++;
    if (act_q.size() != exp_q.size()) $display("FAIL collision_events count: got %0d required %0d", act_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (act_q[k] !== exp_q[k]) $display("FAIL collision_event[%0d]: got %h required %h", k, act_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midword();
    act_q.delete(); exp_q.delete();
    send_word(8'hAA, -1, 1'b0);
    send_word(8'h55, -1, 1'b0);
    send_bits(8'hE7, 3, -1, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    model_reset();
    n_total++;
    if ({d0, d1, d2, b0, b1, b2, wv2, bd2, ab2} !== 75'b0)
      $display("FAIL midreset_state: got %h required 0", {d0, d1, d2, b0, b1, b2, wv2, bd2, ab2});
    else n_pass++;
    cyc(1'b1, 1'b0, 1'b0);
    send_word(8'h11, -1, 1'b0);
    send_word(8'h22, -1, 1'b0);
    send_word(8'h33, -1, 1'b0);
    frame_end();
    n_total++;
    if (b2 !== 24'h332211) $display("FAIL midreset_burst: got %h required 332211", b2);
    else n_pass++;
    n_total++;
    if (act_q.size() != exp_q.size()) $display("FAIL midreset_events count: got %0d required %0d", act_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (act_q[k] !== exp_q[k]) $display("FAIL midreset_event[%0d]: got %h required %h", k, act_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int n, p;
    act_q.delete(); exp_q.delete();
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 6);
      p = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
      for (int j = 0; j < n; j++) send_word(8'($urandom), -1, 1'b1);
      if (p != 0) begin
        send_bits(8'($urandom), p, -1, 1'b1);
        part = p;
      end
      frame_end();
    end
    n_total++;
    if ({d0, d1, d2, b0, b1, b2} !== {last_d[0][7:0], last_d[1][7:0], last_d[2][7:0],
                                      last_b[0][7:0], last_b[1][7:0], last_b[2][23:0]})
      $display("FAIL random_held: got %h required %h", {d0, d1, d2, b0, b1, b2},
               {last_d[0][7:0], last_d[1][7:0], last_d[2][7:0], last_b[0][7:0], last_b[1][7:0], last_b[2][23:0]});
    else n_pass++;
    n_total++;
    if (glitch != 0) $display("FAIL random_atomic: got %0d glitches required 0", glitch);
    else n_pass++;
    n_total++;
    if (act_q.size() != exp_q.size()) $display("FAIL random_events count: got %0d required %0d", act_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (act_q[k] !== exp_q[k]) $display("FAIL random_event[%0d]: got %h required %h", k, act_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  initial begin
    nw[0] = 1; nw[1] = 1; nw[2] = 3;
    model_reset();
    rst = 1'b1; cs_n = 1'b1; sh_data = 1'b0; miso = 1'b0;
    @(negedge ck);
    test_reset();
    test_single_word();
    test_burst();
    test_abort();
    test_collision();
    test_reset_midword();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
